// File: rtl/dffe_multi_if.sv
// Control/data bundle for dffe_multi: operation request in, register state out.
interface dffe_multi_if #(
    parameter int WIDTH = 8
);
    logic             clr;
    logic             e;
    logic [2:0]       op;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             co;
    logic             zf;

    // Driver side: issues clear/enable/op/data, observes register state.
    modport master (
        output clr, e, op, d, sin,
        input  q, co, zf
    );

    // Register side: consumes the request, presents q/co/zf.
    modport slave (
        input  clr, e, op, d, sin,
        output q, co, zf
    );
endinterface

// File: rtl/dffe_multi.sv
// WIDTH-bit enabled register with load/shift/rotate/inc/dec, a registered
// carry/shift-out flag and a combinational zero flag.
module dffe_multi #(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = '0,
    parameter bit                 SAT     = 1'b0
) (
    input  logic           clk,
    input  logic           clrn,
    dffe_multi_if.slave    bus
);
    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROTL = 3'b100;
    localparam logic [2:0] OP_ROTR = 3'b101;
    localparam logic [2:0] OP_INC  = 3'b110;
    localparam logic [2:0] OP_DEC  = 3'b111;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic             r_co;

    logic [WIDTH-1:0] w_q_nxt;
    logic             w_co_nxt;
    logic             w_all1;
    logic             w_zero;

    assign w_all1 = &r_q;
    assign w_zero = ~|r_q;

    // Result of the selected operation; only consumed when e=1, so X on
    // op/d while disabled never reaches the state registers.
    always_comb begin
        w_q_nxt  = r_q;
        w_co_nxt = r_co;
        case (bus.op)
            OP_HOLD: begin
                w_q_nxt  = r_q;
                w_co_nxt = r_co;
            end
            OP_LOAD: begin
                w_q_nxt  = bus.d;
                w_co_nxt = 1'b0;
            end
            OP_SHL: begin
                w_q_nxt  = {r_q[WIDTH-2:0], bus.sin};
                w_co_nxt = r_q[WIDTH-1];
            end
            OP_SHR: begin
                w_q_nxt  = {bus.sin, r_q[WIDTH-1:1]};
                w_co_nxt = r_q[0];
            end
            OP_ROTL: begin
                w_q_nxt  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_co_nxt = r_q[WIDTH-1];
            end
            OP_ROTR: begin
                w_q_nxt  = {r_q[0], r_q[WIDTH-1:1]};
                w_co_nxt = r_q[0];
            end
            OP_INC: begin
                // co flags the all-ones case in both modes; SAT only decides
                // whether q wraps or sticks.
                w_co_nxt = w_all1;
                if (SAT && w_all1) w_q_nxt = r_q;
                else               w_q_nxt = r_q + ONE;
            end
            OP_DEC: begin
                w_co_nxt = w_zero;
                if (SAT && w_zero) w_q_nxt = r_q;
                else               w_q_nxt = r_q - ONE;
            end
            default: begin
                w_q_nxt  = r_q;
                w_co_nxt = r_co;
            end
        endcase
    end

    // State update: async clear, then sync clear, then enable-gated op.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_q  <= RST_VAL;
            r_co <= 1'b0;
        end else if (bus.clr) begin
            r_q  <= '0;
            r_co <= 1'b0;
        end else if (bus.e) begin
            r_q  <= w_q_nxt;
            r_co <= w_co_nxt;
        end
    end

    assign bus.q  = r_q;
    assign bus.co = r_co;
    assign bus.zf = w_zero;
endmodule

// File: tb/tb_dffe_multi.sv
// Directed bench: a wrapping and a saturating instance share one stimulus.
module tb_dffe_multi;
    localparam int         W   = 8;
    localparam logic [7:0] RV  = 8'hA5;

    logic       clk  = 1'b0;
    logic       clrn = 1'b1;
    logic       clr  = 1'b0;
    logic       e    = 1'b0;
    logic [2:0] op   = 3'b000;
    logic [7:0] d    = 8'h00;
    logic       sin  = 1'b0;

    int total = 0;
    int bad   = 0;

    dffe_multi_if #(.WIDTH(W)) if_w ();
    dffe_multi_if #(.WIDTH(W)) if_s ();

    assign if_w.clr = clr;  assign if_s.clr = clr;
    assign if_w.e   = e;    assign if_s.e   = e;
    assign if_w.op  = op;   assign if_s.op  = op;
    assign if_w.d   = d;    assign if_s.d   = d;
    assign if_w.sin = sin;  assign if_s.sin = sin;

    dffe_multi #(.WIDTH(W), .RST_VAL(RV), .SAT(1'b0)) dut_w (
        .clk(clk), .clrn(clrn), .bus(if_w.slave)
    );
    dffe_multi #(.WIDTH(W), .RST_VAL(RV), .SAT(1'b1)) dut_s (
        .clk(clk), .clrn(clrn), .bus(if_s.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [7:0] dv, input logic s);
        e = 1'b1; op = o; d = dv; sin = s;
        step();
    endtask

    initial begin
        // Async reset between edges
        #2 clrn = 1'b0;
        #1;
        chk("rst_q",  if_w.q,  RV);
        chk("rst_co", {7'b0, if_w.co}, 8'h00);
        chk("rst_zf", {7'b0, if_w.zf}, 8'h00);
        chk("rst_q_s", if_s.q, RV);
        @(negedge clk) clrn = 1'b1;

        // Disabled with X on op/d: hold
        e = 1'b0; op = 3'bxxx; d = 8'hxx;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_e0", if_w.q, RV);
        end
        chk("hold_e0_co", {7'b0, if_w.co}, 8'h00);

        // Load and enable gating
        do_op(3'b001, 8'h3C, 1'b0);
        chk("load_q",  if_w.q, 8'h3C);
        chk("load_co", {7'b0, if_w.co}, 8'h00);
        e = 1'b0; op = 3'b001; d = 8'hFF;
        step();
        chk("gate_q", if_w.q, 8'h3C);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_q",  if_w.q, 8'h00);
        chk("clr_zf", {7'b0, if_w.zf}, 8'h01);

        // Shift / rotate from 81
        do_op(3'b001, 8'h81, 1'b0);
        do_op(3'b010, 8'h00, 1'b0);
        chk("shl_q", if_w.q, 8'h02);  chk("shl_co", {7'b0, if_w.co}, 8'h01);
        do_op(3'b011, 8'h00, 1'b1);
        chk("shr_q", if_w.q, 8'h81);  chk("shr_co", {7'b0, if_w.co}, 8'h00);
        do_op(3'b101, 8'h00, 1'b0);
        chk("rotr_q", if_w.q, 8'hC0); chk("rotr_co", {7'b0, if_w.co}, 8'h01);
        do_op(3'b100, 8'h00, 1'b0);
        chk("rotl_q", if_w.q, 8'h81); chk("rotl_co", {7'b0, if_w.co}, 8'h01);

        // Wrap vs saturate around all-ones / zero
        do_op(3'b001, 8'hFF, 1'b0);
        do_op(3'b110, 8'h00, 1'b0);
        chk("winc_q", if_w.q, 8'h00); chk("winc_co", {7'b0, if_w.co}, 8'h01);
        chk("winc_zf", {7'b0, if_w.zf}, 8'h01);
        chk("sinc_q", if_s.q, 8'hFF); chk("sinc_co", {7'b0, if_s.co}, 8'h01);
        do_op(3'b111, 8'h00, 1'b0);
        chk("wdec1_q", if_w.q, 8'hFF); chk("wdec1_co", {7'b0, if_w.co}, 8'h01);
        chk("sdec1_q", if_s.q, 8'hFE); chk("sdec1_co", {7'b0, if_s.co}, 8'h00);
        do_op(3'b111, 8'h00, 1'b0);
        chk("wdec2_q", if_w.q, 8'hFE); chk("wdec2_co", {7'b0, if_w.co}, 8'h00);
        chk("sdec2_q", if_s.q, 8'hFD);

        // Saturating increments from FE
        do_op(3'b001, 8'hFE, 1'b0);
        do_op(3'b110, 8'h00, 1'b0);
        chk("sinc1_q", if_s.q, 8'hFF); chk("sinc1_co", {7'b0, if_s.co}, 8'h00);
        chk("winc1_q", if_w.q, 8'hFF);
        do_op(3'b110, 8'h00, 1'b0);
        chk("sinc2_q", if_s.q, 8'hFF); chk("sinc2_co", {7'b0, if_s.co}, 8'h01);
        chk("winc2_q", if_w.q, 8'h00);
        do_op(3'b110, 8'h00, 1'b0);
        chk("sinc3_q", if_s.q, 8'hFF); chk("sinc3_co", {7'b0, if_s.co}, 8'h01);
        chk("winc3_q", if_w.q, 8'h01); chk("winc3_co", {7'b0, if_w.co}, 8'h00);

        // Saturating decrements from 01
        do_op(3'b001, 8'h01, 1'b0);
        do_op(3'b111, 8'h00, 1'b0);
        chk("sdec_a_q", if_s.q, 8'h00); chk("sdec_a_co", {7'b0, if_s.co}, 8'h00);
        do_op(3'b111, 8'h00, 1'b0);
        chk("sdec_b_q", if_s.q, 8'h00); chk("sdec_b_co", {7'b0, if_s.co}, 8'h01);
        chk("wdec_b_q", if_w.q, 8'hFF); chk("wdec_b_co", {7'b0, if_w.co}, 8'h01);

        // Sync clear beats enable/op
        do_op(3'b001, 8'h10, 1'b0);
        clr = 1'b1; e = 1'b1; op = 3'b110;
        step();
        clr = 1'b0;
        chk("clr_pri_q", if_w.q, 8'h00);
        chk("clr_pri_co", {7'b0, if_w.co}, 8'h00);

        // Increment stream interrupted by async reset
        do_op(3'b110, 8'h00, 1'b0);
        chk("stream1", if_w.q, 8'h01);
        do_op(3'b110, 8'h00, 1'b0);
        chk("stream2", if_w.q, 8'h02);
        #2 clrn = 1'b0;
        #1;
        chk("mid_rst_q", if_w.q, RV);
        chk("mid_rst_co", {7'b0, if_w.co}, 8'h00);
        chk("mid_rst_zf", {7'b0, if_w.zf}, 8'h00);
        @(negedge clk) clrn = 1'b1;
        step();
        chk("resume1_w", if_w.q, 8'hA6);
        chk("resume1_s", if_s.q, 8'hA6);
        step();
        chk("resume2_w", if_w.q, 8'hA7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
